// File: rtl/piso_pkg.sv
// Shared types and helpers for the serializer / deserializer pair.
package piso_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    // Bit-counter width for a given word width: max(1, clog2(width)).
    function automatic int cnt_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Modulo-WIDTH bit counter with synchronous active-low clear and terminal count.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic [cnt_w(WIDTH)-1:0]   count,
    output logic                      tc
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Count 0..WIDTH-1 while enabled, wrapping to 0 after the last value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in / serial-out transmitter with valid/ready load and frame markers.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic             tc;
    logic             shifting;
    logic             accept;

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (shifting),
        .count (count),
        .tc    (tc)
    );

    assign accept = load_valid && load_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: leave SHIFT only when the last bit goes out with no new word behind it.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = ST_SHIFT;
            ST_SHIFT: if (tc && !accept) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Handshake and shift enable decoded from state; no accept while in reset.
    always_comb begin
        load_ready = 1'b0;
        shifting   = 1'b0;
        case (state)
            ST_IDLE: begin
                load_ready = rst;
            end
            ST_SHIFT: begin
                shifting   = 1'b1;
                load_ready = rst && tc;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

    // Shift register and registered serial outputs; a new word replaces the shift on accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg       <= '0;
            ser_out     <= IDLE_LEVEL;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            if (shifting) begin
                ser_out     <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                ser_valid   <= 1'b1;
                frame_start <= (count == '0);
                frame_end   <= tc;
            end else begin
                ser_out     <= IDLE_LEVEL;
                ser_valid   <= 1'b0;
                frame_start <= 1'b0;
                frame_end   <= 1'b0;
            end
            if (accept) begin
                shreg <= load_data;
            end else if (shifting) begin
                shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: three instances (8-bit MSB-first, 8-bit LSB-first
// with idle level 1, 1-bit) checked each cycle against a bit-queue model.
module tb_piso_shift_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [0:0] d2;
    logic [2:0] lv;
    logic [2:0] rdy;
    logic [2:0] so;
    logic [2:0] sv;
    logic [2:0] fs;
    logic [2:0] fe;

    int unsigned errors = 0;
    int unsigned checks = 0;

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .load_data(d0), .load_valid(lv[0]), .load_ready(rdy[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]), .frame_end(fe[0]));

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .load_data(d1), .load_valid(lv[1]), .load_ready(rdy[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]), .frame_end(fe[1]));

    piso_shift_tx #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_one (
        .clk(clk), .rst(rst), .load_data(d2), .load_valid(lv[2]), .load_ready(rdy[2]),
        .ser_out(so[2]), .ser_valid(sv[2]), .frame_start(fs[2]), .frame_end(fe[2]));

    // Reference model: per instance, a queue of bits still to appear on ser_out,
    // each tagged {bit, first, last}; ex holds {valid, out, start, end} now shown.
    logic [2:0]  mq [3][256];
    int unsigned mh [3];
    int unsigned mt [3];
    logic [3:0]  ex [3];

    function automatic int wid(input int i);
        return (i == 2) ? 1 : 8;
    endfunction

    function automatic logic msbf(input int i);
        return (i != 1);
    endfunction

    function automatic logic idl(input int i);
        return (i == 1);
    endfunction

    function automatic logic [7:0] word(input int i);
        case (i)
            0:       return d0;
            1:       return d1;
            default: return {7'b0, d2};
        endcase
    endfunction

    function automatic int unsigned msize(input int i);
        return mt[i] - mh[i];
    endfunction

    // Ready whenever at most one bit of the current word is still to be shown.
    function automatic logic [4:0] expv(input int i);
        return {rst && (msize(i) <= 1), ex[i]};
    endfunction

    function automatic logic [4:0] obs(input int i);
        return {rdy[i], sv[i], so[i], fs[i], fe[i]};
    endfunction

    task automatic step();
        logic [2:0] acc;
        logic [7:0] wd [3];
        logic       r;
        r = rst;
        for (int i = 0; i < 3; i++) begin
            acc[i] = rst && lv[i] && (msize(i) <= 1);
            wd[i]  = word(i);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                mh[i] = mt[i];
                ex[i] = {1'b0, idl(i), 2'b00};
            end else begin
                if (msize(i) > 0) begin
                    ex[i] = {1'b1, mq[i][mh[i] % 256]};
                    mh[i]++;
                end else begin
                    ex[i] = {1'b0, idl(i), 2'b00};
                end
                if (acc[i]) begin
                    for (int k = 0; k < wid(i); k++) begin
                        int b;
                        b = msbf(i) ? wid(i) - 1 - k : k;
                        mq[i][mt[i] % 256] = {wd[i][b], (k == 0), (k == wid(i) - 1)};
                        mt[i]++;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; lv = '1; d0 = 8'hFF; d1 = 8'hFF; d2 = 1'b1;
        repeat (2) begin
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL reset dut%0d t=%0t got=%b exp=%b", i, $time, obs(i), expv(i));
                end
            end
        end
        rst = 1'b1; lv = '0;
        #1;
        checks++;
        if (rdy !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready t=%0t got=%b exp=111", $time, rdy);
        end
    endtask

    task automatic test_bit_order();
        logic [7:0] c0 = '0;
        logic [7:0] c1 = '0;
        int         v0 = 0;
        d0 = 8'hA5; d1 = 8'h01; d2 = 1'($urandom); lv = 3'b111;
        step();
        lv = '0;
        repeat (11) begin
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL bit_order dut%0d t=%0t got=%b exp=%b", i, $time, obs(i), expv(i));
                end
            end
            if (sv[0]) begin c0 = {c0[6:0], so[0]}; v0++; end
            if (sv[1]) c1 = {so[1], c1[7:1]};
        end
        checks++;
        if (c0 !== 8'hA5 || c1 !== 8'h01 || v0 != 8) begin
            errors++;
            $display("FAIL bit_order_words got=%h/%h/%0d exp=a5/01/8", c0, c1, v0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s = '0;
        int          n = 0;
        int          cyc = 0;
        int          first = -1;
        int          last = -1;
        int          nv = 0;
        logic        a;
        d0 = 8'hFF; lv = 3'b001;
        repeat (22) begin
            a = rdy[0] && lv[0];
            step();
            cyc++;
            if (a) begin
                n++;
                if (n == 1) d0 = 8'h00;
                else lv[0] = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL back_to_back dut%0d t=%0t got=%b exp=%b", i, $time, obs(i), expv(i));
                end
            end
            if (sv[0]) begin
                s = {s[14:0], so[0]};
                nv++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        checks++;
        if (s !== 16'hFF00 || nv != 16 || last - first + 1 != 16) begin
            errors++;
            $display("FAIL back_to_back_stream got=%h n=%0d span=%0d exp=ff00 n=16 span=16", s, nv, last - first + 1);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] c = '0;
        d0 = 8'hF0; lv = 3'b001;
        step();
        lv = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
                errors++;
                $display("FAIL reset_mid dut%0d t=%0t got=%b exp=%b", i, $time, obs(i), expv(i));
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rdy[0] !== 1'b1 || sv[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release got rdy=%b sv=%b exp rdy=1 sv=0", rdy[0], sv[0]);
        end
        d0 = 8'h3C; lv = 3'b001;
        step();
        lv = '0;
        repeat (10) begin
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL reset_mid_next dut%0d t=%0t got=%b exp=%b", i, $time, obs(i), expv(i));
                end
            end
            if (sv[0]) c = {c[6:0], so[0]};
        end
        checks++;
        if (c !== 8'h3C) begin
            errors++;
            $display("FAIL reset_mid_word got=%h exp=3c", c);
        end
    endtask

    task automatic test_data_change();
        logic [7:0] c = '0;
        int         nv = 0;
        d0 = 8'hC3; lv = 3'b001;
        step();
        for (int k = 0; k < 17; k++) begin
            d0 = 8'($urandom);
            lv[0] = (k < 7);
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL data_change dut%0d t=%0t got=%b exp=%b", i, $time, obs(i), expv(i));
                end
            end
            if (sv[0]) begin c = {c[6:0], so[0]}; nv++; end
        end
        lv = '0;
        checks++;
        if (c !== 8'hC3 || nv != 8) begin
            errors++;
            $display("FAIL data_change_word got=%h n=%0d exp=c3 n=8", c, nv);
        end
    endtask

    task automatic test_width1();
        logic [2:0] pat = 3'b101;
        logic [2:0] c = '0;
        int         nv = 0;
        int         nmark = 0;
        lv = 3'b100;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin
                d2 = pat[2 - k];
            end else begin
                lv[2] = 1'b0;
            end
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL width1 dut%0d t=%0t got=%b exp=%b", i, $time, obs(i), expv(i));
                end
            end
            checks++;
            if (rdy[2] !== 1'b1) begin
                errors++;
                $display("FAIL width1_ready t=%0t got=%b exp=1", $time, rdy[2]);
            end
            if (sv[2]) begin
                c = {c[1:0], so[2]};
                nv++;
                if (fs[2] && fe[2]) nmark++;
            end
        end
        checks++;
        if (c !== 3'b101 || nv != 3 || nmark != 3) begin
            errors++;
            $display("FAIL width1_stream got=%b n=%0d marks=%0d exp=101 n=3 marks=3", c, nv, nmark);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            lv  = 3'($urandom);
            d0  = 8'($urandom);
            d1  = 8'($urandom);
            d2  = 1'($urandom);
            rst = ($urandom_range(0, 39) != 0);
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL random dut%0d t=%0t got=%b exp=%b", i, $time, obs(i), expv(i));
                end
            end
        end
        rst = 1'b1; lv = '0;
        repeat (10) begin
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL random_drain dut%0d t=%0t got=%b exp=%b", i, $time, obs(i), expv(i));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; lv = '0; d0 = '0; d1 = '0; d2 = '0;
        for (int i = 0; i < 3; i++) begin
            mh[i] = 0;
            mt[i] = 0;
            ex[i] = {1'b0, idl(i), 2'b00};
        end
        #1;
        test_reset();
        test_bit_order();
        test_back_to_back();
        test_reset_mid();
        test_data_change();
        test_width1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
